// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Time-multiplexed FIR controller. It keeps NUM_COEFFS coefficients and the
// last NUM_COEFFS samples, and runs one shared multiply-accumulate over the
// taps, one tap per cycle. The result is saturated to RESULT_WIDTH bits.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   coef_wr_en    coefficient write strobe (honoured only while idle)
//   coef_wr_addr  tap index to write
//   coef_wr_data  coefficient value
//   in_valid      sample offered
//   in_data       sample value (unsigned)
//   in_ready      high while idle; a sample is taken on in_valid & in_ready
//   out_valid     registered result-valid flag
//   out_data      registered saturated filter result
//   out_ready     consumer takes the result on out_valid & out_ready
//   busy          high while computing or holding a result
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int COEFF_WIDTH  = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int NUM_COEFFS   = 8,
    parameter int ADDR_W       = $clog2(NUM_COEFFS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_wr_en,
    input  logic [ADDR_W-1:0]       coef_wr_addr,
    input  logic [COEFF_WIDTH-1:0]  coef_wr_data,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [RESULT_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy
);

    // Wide enough that summing NUM_COEFFS full-scale products never wraps.
    localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [DATA_WIDTH-1:0]   hist_r [NUM_COEFFS];
    logic [COEFF_WIDTH-1:0]  coef_r [NUM_COEFFS];
    logic [ADDR_W-1:0]       wptr_r;
    logic [ADDR_W-1:0]       k_r;
    logic [ACC_W-1:0]        acc_r;
    logic                    out_valid_r;
    logic [RESULT_WIDTH-1:0] out_data_r;

    logic [ADDR_W-1:0]       rd_idx_s;
    logic [ACC_W-1:0]        prod_s;
    logic [ACC_W-1:0]        acc_next_s;
    logic                    last_tap_s;

    // Clamp the accumulator to the output range: any bit above RESULT_WIDTH
    // means the sum exceeds the largest representable result.
    function automatic logic [RESULT_WIDTH-1:0] sat(input logic [ACC_W-1:0] value);
        logic [RESULT_WIDTH-1:0] res;
        if (|value[ACC_W-1:RESULT_WIDTH]) begin
            res = {RESULT_WIDTH{1'b1}};
        end else begin
            res = value[RESULT_WIDTH-1:0];
        end
        return res;
    endfunction

    // The newest sample sits one slot behind wptr_r, so tap k reads
    // wptr_r-1-k; modular wrap comes from the ADDR_W-bit arithmetic.
    assign rd_idx_s   = wptr_r - ADDR_W'(1) - k_r;
    assign prod_s     = ACC_W'(hist_r[rd_idx_s]) * ACC_W'(coef_r[k_r]);
    assign acc_next_s = acc_r + prod_s;
    assign last_tap_s = (k_r == ADDR_W'(NUM_COEFFS - 1));

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r == MAC) || (state_r == OUT);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = MAC;
                end else begin
                    state_s = IDLE;
                end
            end
            MAC: begin
                if (last_tap_s) begin
                    state_s = OUT;
                end else begin
                    state_s = MAC;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: coefficient/history storage, accumulator and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r      <= '0;
            k_r         <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            for (int i = 0; i < NUM_COEFFS; i++) begin
                hist_r[i] <= '0;
                coef_r[i] <= COEFF_WIDTH'(i + 1);
            end
        end else begin
            case (state_r)
                IDLE: begin
                    // A write and an accept in the same cycle both land; the
                    // MAC starts next cycle and therefore sees the new value.
                    if (coef_wr_en) begin
                        coef_r[coef_wr_addr] <= coef_wr_data;
                    end
                    if (in_valid) begin
                        hist_r[wptr_r] <= in_data;
                        wptr_r         <= wptr_r + ADDR_W'(1);
                        acc_r          <= '0;
                        k_r            <= '0;
                    end
                end
                MAC: begin
                    acc_r <= acc_next_s;
                    k_r   <= k_r + ADDR_W'(1);
                    if (last_tap_s) begin
                        out_data_r  <= sat(acc_next_s);
                        out_valid_r <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
